// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue unit.
package fetch_pkg;

    typedef enum logic {IDLE, RUN} fetch_state_e;

    localparam int unsigned INSTR_BYTES    = 4;
    localparam logic [3:0]  FETCH_MASK_ALL = 4'b1111;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO with synchronous active-low clear; used for both the
// instruction+PC queue and the outstanding-request PC-tag list.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4,
    localparam int unsigned CW   = cnt_w(Depth)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic [CW-1:0]    count
);
    localparam int unsigned PW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    rptr, wptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rptr];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop)
                rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Callers guarantee room by credit; a push into a full FIFO is a design bug.
    always_ff @(posedge clk) begin
        if (clr_n)
            assert (!(push && !do_pop && count == CW'(Depth)));
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch with in-order prefetch queue, redirect flush and stale-drop.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          Depth       = 4,
    parameter logic [DataWidth-1:0] ResetVector = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect,
    input  logic [DataWidth-1:0] redirect_addr,
    input  logic                 mem_busy,
    input  logic                 imem_valid,
    input  logic [DataWidth-1:0] imem_rdata,
    output logic                 imem_req,
    output logic [DataWidth-1:0] imem_addr,
    output logic                 imem_we_re,
    output logic [3:0]           imem_mask,
    input  logic                 instr_ready,
    output logic                 instr_valid,
    output logic [DataWidth-1:0] instruction,
    output logic [DataWidth-1:0] instr_pc
);
    localparam int unsigned CW = cnt_w(Depth);

    fetch_state_e           state, state_nxt;
    logic [DataWidth-1:0]   fetch_pc;
    logic [CW-1:0]          inflight, drop_cnt, q_count, tag_count;
    logic [CW:0]            occupancy;
    logic [2*DataWidth-1:0] q_head;
    logic [DataWidth-1:0]   tag_head;
    logic                   resp_keep, q_push, q_pop, q_nonempty, clr_n;

    assign occupancy  = {1'b0, q_count} + {1'b0, inflight};
    assign resp_keep  = imem_valid && (drop_cnt == '0);
    assign q_nonempty = (q_count != '0);
    assign clr_n      = rst && !redirect;
    assign q_pop      = q_nonempty && instr_ready && !redirect;

    assign imem_addr  = fetch_pc;
    assign imem_we_re = 1'b0;
    assign imem_mask  = FETCH_MASK_ALL;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Credit counts queued words plus everything in flight, stale ones included.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     imem_req  = !mem_busy && !redirect && (occupancy < (CW+1)'(Depth));
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FETCH_BYPASS_EN
    logic fwd;
    assign fwd         = !q_nonempty && resp_keep && !redirect;
    assign q_push      = resp_keep && !(fwd && instr_ready);
    assign instr_valid = (q_nonempty || fwd) && !redirect;
    assign instruction = q_nonempty ? q_head[2*DataWidth-1:DataWidth] : (fwd ? imem_rdata : '0);
    assign instr_pc    = q_nonempty ? q_head[DataWidth-1:0]           : (fwd ? tag_head   : '0);
`else
    assign q_push      = resp_keep;
    assign instr_valid = q_nonempty && !redirect;
    assign instruction = q_nonempty ? q_head[2*DataWidth-1:DataWidth] : '0;
    assign instr_pc    = q_nonempty ? q_head[DataWidth-1:0]           : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= ResetVector;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(imem_req) - CW'(imem_valid);
            if (redirect) begin
                // Everything still outstanding after this cycle is stale.
                fetch_pc <= redirect_addr & ~DataWidth'(INSTR_BYTES - 1);
                drop_cnt <= inflight - CW'(imem_valid);
            end else begin
                if (imem_req)
                    fetch_pc <= fetch_pc + DataWidth'(INSTR_BYTES);
                if (imem_valid && drop_cnt != '0)
                    drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_n)
            assert (!(resp_keep && tag_count == '0));
    end

    fetch_fifo #(.Width(DataWidth), .Depth(Depth)) u_tag_fifo (
        .clk       (clk),
        .clr_n     (clr_n),
        .push      (imem_req),
        .push_data (fetch_pc),
        .pop       (resp_keep),
        .head      (tag_head),
        .count     (tag_count)
    );

    fetch_fifo #(.Width(2*DataWidth), .Depth(Depth)) u_instr_fifo (
        .clk       (clk),
        .clr_n     (clr_n),
        .push      (q_push),
        .push_data ({imem_rdata, tag_head}),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: in-order memory model, request/response scoreboard
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_queue_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0;
`ifdef FETCH_BYPASS_EN
    localparam int LAT0 = 1;
`else
    localparam int LAT0 = 2;
`endif

    logic        clk = 0, rst = 0, redirect = 0, mem_busy = 0, imem_valid = 0, instr_ready = 0;
    logic [31:0] redirect_addr = 0, imem_rdata = 0;
    logic        imem_req, imem_we_re, instr_valid;
    logic [31:0] imem_addr, instruction, instr_pc;
    logic [3:0]  imem_mask;

    fetch_queue_unit #(.DataWidth(32), .Depth(DEPTH), .ResetVector(RV)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
        .mem_busy(mem_busy), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_we_re(imem_we_re),
        .imem_mask(imem_mask), .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instruction(instruction), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
    typedef struct { int cyc; logic [31:0] v; } ev_t;

    mreq_t       mem_q[$];
    logic [31:0] avail_q[$];
    ev_t         req_log[$], del_log[$];
    int          cyc = 0, lat = 1, n_checks = 0, n_err = 0, rst_edges = 0;
    bit          run = 0;
    logic [31:0] m_pc = RV;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] req_a(input int i);
        if (i < req_log.size()) return req_log[i].v;
        return 'x;
    endfunction
    function automatic logic [31:0] req_c(input int i);
        if (i < req_log.size()) return 32'(req_log[i].cyc);
        return 'x;
    endfunction
    function automatic logic [31:0] del_a(input int i);
        if (i < del_log.size()) return del_log[i].v;
        return 'x;
    endfunction
    function automatic logic [31:0] del_c(input int i);
        if (i < del_log.size()) return 32'(del_log[i].cyc);
        return 'x;
    endfunction

    // In-order memory: one response per cycle, no earlier than its due cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = word_of(mem_q[0].addr);
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
        end
    end

    // Compare against the model, then advance the model across the coming edge.
    bit          m_byp, m_req, m_v;
    logic [31:0] m_head;
    mreq_t       m_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (rst_edges > 0) begin
                chk("rst_imem_req", imem_req, 1'b0);
                chk("rst_imem_addr", imem_addr, RV);
                chk("rst_instr_valid", instr_valid, 1'b0);
                chk("rst_instruction", instruction, 32'h0);
                chk("rst_instr_pc", instr_pc, 32'h0);
            end
            rst_edges++;
            mem_q.delete();
            avail_q.delete();
            run  = 0;
            m_pc = RV;
        end else begin
            rst_edges = 0;
            m_byp = 0;
`ifdef FETCH_BYPASS_EN
            m_byp = avail_q.size() == 0 && imem_valid && mem_q.size() > 0 && !mem_q[0].stale && !redirect;
`endif
            m_req  = run && !mem_busy && !redirect && (avail_q.size() + mem_q.size() < DEPTH);
            m_v    = (avail_q.size() > 0 || m_byp) && !redirect;
            m_head = (avail_q.size() > 0) ? avail_q[0] : (mem_q.size() > 0 ? mem_q[0].addr : 32'h0);

            chk("imem_req", imem_req, m_req);
            if (m_req) chk("imem_addr", imem_addr, m_pc);
            chk("imem_we_re", imem_we_re, 1'b0);
            chk("imem_mask", imem_mask, 4'hF);
            chk("instr_valid", instr_valid, m_v);
            if (m_v) begin
                chk("instr_pc", instr_pc, m_head);
                chk("instruction", instruction, word_of(m_head));
            end
            if (avail_q.size() == 0 && !m_byp) chk("empty_instruction", instruction, 32'h0);

            if (imem_req) req_log.push_back('{cyc, imem_addr});
            if (instr_valid && instr_ready) del_log.push_back('{cyc, instr_pc});

            if (m_v && instr_ready && avail_q.size() > 0) void'(avail_q.pop_front());
            if (imem_valid && mem_q.size() > 0) begin
                m_e = mem_q.pop_front();
                if (!m_e.stale && !redirect && !(m_byp && instr_ready)) avail_q.push_back(m_e.addr);
            end
            if (redirect) begin
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                avail_q.delete();
                m_pc = redirect_addr & ~32'h3;
            end else if (m_req) begin
                mem_q.push_back('{m_pc, cyc + lat, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            run = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench at the start of the first RUN cycle with empty logs.
    task automatic do_reset(input bit rdy, input int l);
        rst = 0; redirect = 0; mem_busy = 0; instr_ready = rdy; lat = l;
        tick(3);
        rst = 1;
        tick(1);
        req_log.delete();
        del_log.delete();
    endtask

    int t0, rc;
    initial begin
        // Free run, 1-cycle memory.
        do_reset(1'b1, 1);
        t0 = cyc;
        tick(12);
        chk("A_first_req_addr", req_a(0), 32'h0);
        chk("A_first_req_cyc", req_c(0), 32'(t0));
        chk("A_req_seq", {req_a(1)[7:0], req_a(2)[7:0], req_a(3)[7:0]}, 32'h00_04_08_0C);
        chk("A_first_pc", del_a(0), 32'h0);
        chk("A_first_latency", del_c(0), 32'(t0 + LAT0));
        chk("A_deliveries", 32'(del_log.size()), 32'(12 - LAT0));
        chk("A_one_per_cycle", del_c(del_log.size() - 1) - del_c(0), 32'(del_log.size() - 1));

        // Decode stalled: credit limit reached, then drain in order.
        do_reset(1'b0, 1);
        tick(10);
        chk("B_req_count", 32'(req_log.size()), 32'd4);
        chk("B_req_idle", imem_req, 1'b0);
        instr_ready = 1;
        tick(8);
        chk("B_drain0", del_a(0), 32'h0);
        chk("B_drain1", del_a(1), 32'h4);
        chk("B_drain2", del_a(2), 32'h8);
        chk("B_drain3", del_a(3), 32'hC);
        chk("B_drain4", del_a(4), 32'h10);

        // Latency 3, redirect with two requests in flight.
        do_reset(1'b1, 3);
        tick(2);
        redirect = 1; redirect_addr = 32'h100;
        tick(1);
        redirect = 0;
        rc = cyc;
        tick(10);
        chk("C_target_req", req_a(2), 32'h100);
        chk("C_target_req_cyc", req_c(2), 32'(rc));
        chk("C_first_pc", del_a(0), 32'h100);

        // mem_busy blocks requests while the full queue still drains.
        do_reset(1'b0, 1);
        tick(6);
        mem_busy = 1; instr_ready = 1;
        tick(5);
        mem_busy = 0;
        chk("D_pops_while_busy", 32'(del_log.size()), 32'd4);
        chk("D_no_req_while_busy", 32'(req_log.size()), 32'd4);
        tick(2);
        chk("D_resume_addr", req_a(4), 32'h10);

        // Redirect coincident with a response; unaligned target.
        do_reset(1'b1, 3);
        tick(3);
        redirect = 1; redirect_addr = 32'h203;
        tick(1);
        redirect = 0;
        rc = cyc;
        tick(10);
        chk("E_target_req", req_a(3), 32'h200);
        chk("E_target_req_cyc", req_c(3), 32'(rc));
        chk("E_first_pc", del_a(0), 32'h200);

        // Back-to-back redirects (last wins) into an address-wrap sequence.
        mem_busy = 1; lat = 1;
        tick(6);
        redirect = 1; redirect_addr = 32'h300;
        tick(1);
        redirect_addr = 32'hFFFF_FFF8; mem_busy = 0;
        tick(1);
        redirect = 0;
        req_log.delete();
        del_log.delete();
        rc = cyc;
        tick(8);
        chk("F_req0", req_a(0), 32'hFFFF_FFF8);
        chk("F_req0_cyc", req_c(0), 32'(rc));
        chk("F_req1", req_a(1), 32'hFFFF_FFFC);
        chk("F_req_wrap", req_a(2), 32'h0);
        chk("F_pc0", del_a(0), 32'hFFFF_FFF8);
        chk("F_pc1", del_a(1), 32'hFFFF_FFFC);
        chk("F_pc_wrap", del_a(2), 32'h0);

        // Reset in the middle of traffic.
        do_reset(1'b1, 1);
        t0 = cyc;
        tick(4);
        chk("G_req_after_reset", req_a(0), RV);
        chk("G_req_cyc", req_c(0), 32'(t0));
        chk("G_first_pc", del_a(0), RV);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
